// File: rtl/param_cache_pkg.sv
// Shared types for the rv32i memory port and the parametrised cache.
package rv32i_types;
  typedef logic [31:0] rv32i_word;
  typedef logic [3:0]  rv32i_mem_wmask;
endpackage

package cache_types;
  localparam int LINE_BITS   = 256;
  localparam int OFFSET_BITS = 5;

  // Controller states; the encoding is also exported on fsm_state.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_t;
endpackage

// File: rtl/param_cache_plru_tree.sv
// Tree pseudo-LRU for one set, heap indexed (root 0, children 2i+1 / 2i+2).
// A node value of 0 points at its lower-index subtree, 1 at the upper one.
module plru_tree #(
  parameter int WAYS = 4
) (
  input  logic [WAYS-2:0]         bits,
  input  logic [$clog2(WAYS)-1:0] access_way,
  output logic [WAYS-2:0]         next_bits,
  output logic [$clog2(WAYS)-1:0] victim
);
  localparam int WB = $clog2(WAYS);

  // Walk the tree for the victim, then re-walk along the accessed way's path
  // flipping each node to point away from it.
  always_comb begin
    int  node;
    logic b;
    next_bits = bits;
    victim    = '0;
    node      = 0;
    for (int l = 0; l < WB; l++) begin
      b = 1'b0;
      for (int n = 0; n < WAYS - 1; n++) if (n == node) b = bits[n];
      victim[WB-1-l] = b;
      node = 2 * node + 1 + (b ? 1 : 0);
    end
    node = 0;
    for (int l = 0; l < WB; l++) begin
      for (int n = 0; n < WAYS - 1; n++)
        if (n == node) next_bits[n] = ~access_way[WB-1-l];
      node = 2 * node + 1 + (access_way[WB-1-l] ? 1 : 0);
    end
  end
endmodule

// File: rtl/param_cache.sv
// N-way set-associative write-back / write-allocate cache with tree PLRU.
// CPU side: mem_read/mem_write are held until mem_resp (valid/ready style:
// a request completes in the cycle mem_resp is high). Memory side:
// pmem_read/pmem_write and their address/data are held until pmem_resp.
module param_cache
  import cache_types::*;
  import rv32i_types::*;
#(
  parameter int WAYS = 4,
  parameter int SETS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  input  logic [3:0]   mem_byte_enable,
  input  logic         mem_read,
  input  logic         mem_write,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic         is_hit,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  output logic         pmem_read,
  output logic         pmem_write,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count,
  output logic [1:0]   fsm_state
);
  localparam int IDX      = $clog2(SETS);
  localparam int WB       = $clog2(WAYS);
  localparam int TAG_BITS = 32 - OFFSET_BITS - IDX;

  logic [LINE_BITS-1:0] data_q  [SETS][WAYS];
  logic [TAG_BITS-1:0]  tag_q   [SETS][WAYS];
  logic [WAYS-1:0]      valid_q [SETS];
  logic [WAYS-1:0]      dirty_q [SETS];
  logic [WAYS-2:0]      plru_q  [SETS];

  state_t               state_q;
  logic [WB-1:0]        victim_q;
  logic                 missed_q;

  logic [IDX-1:0]       index;
  logic [TAG_BITS-1:0]  tag;
  logic [2:0]           wsel;
  logic                 req, hit_any, inv_any;
  logic [WB-1:0]        hit_way, inv_way, plru_victim, new_victim;
  logic [WAYS-2:0]      plru_next;
  rv32i_word            old_word, new_word;
  logic [LINE_BITS-1:0] wr_line;
  logic                 unused_addr;

  assign index       = mem_address[IDX+OFFSET_BITS-1:OFFSET_BITS];
  assign tag         = mem_address[31:IDX+OFFSET_BITS];
  assign wsel        = mem_address[4:2];
  assign unused_addr = &{1'b0, mem_address[1:0]};
  assign req         = mem_read | mem_write;
  assign fsm_state   = state_q;

  // Tag compare across ways, plus lowest-index invalid way for allocation.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[index][w] && tag_q[index][w] == tag) begin
        hit_any = 1'b1;
        hit_way = WB'(w);
      end
      if (!valid_q[index][w]) begin
        inv_any = 1'b1;
        inv_way = WB'(w);
      end
    end
  end

  plru_tree #(.WAYS(WAYS)) u_plru (
    .bits       (plru_q[index]),
    .access_way (hit_way),
    .next_bits  (plru_next),
    .victim     (plru_victim)
  );

  assign new_victim = inv_any ? inv_way : plru_victim;

  // Read word of the hit way and the byte-merged line for a write hit.
  always_comb begin
    old_word = data_q[index][hit_way][{wsel, 5'b0} +: 32];
    new_word = old_word;
    for (int b = 0; b < 4; b++)
      if (mem_byte_enable[b]) new_word[b*8 +: 8] = mem_wdata[b*8 +: 8];
    wr_line = data_q[index][hit_way];
    wr_line[{wsel, 5'b0} +: 32] = new_word;
  end

  assign is_hit       = (state_q == IDLE) && req && hit_any;
  assign mem_resp     = is_hit;
  assign mem_rdata    = old_word;
  assign pmem_read    = (state_q == FILL);
  assign pmem_write   = (state_q == WRITEBACK);
  assign pmem_wdata   = data_q[index][victim_q];
  assign pmem_address = (state_q == WRITEBACK) ?
                        {tag_q[index][victim_q], index, 5'b0} :
                        {tag, index, 5'b0};

  // Controller, metadata bits and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      victim_q   <= '0;
      missed_q   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (is_hit) begin
            plru_q[index] <= plru_next;
            missed_q      <= 1'b0;
            if (!missed_q) hit_count <= hit_count + 32'd1;
            if (mem_write) dirty_q[index][hit_way] <= 1'b1;
          end else if (req) begin
            victim_q   <= new_victim;
            missed_q   <= 1'b1;
            miss_count <= miss_count + 32'd1;
            state_q    <= (valid_q[index][new_victim] && dirty_q[index][new_victim]) ?
                          WRITEBACK : FILL;
          end
        end
        WRITEBACK: if (pmem_resp) state_q <= FILL;
        FILL: begin
          if (pmem_resp) begin
            valid_q[index][victim_q] <= 1'b1;
            dirty_q[index][victim_q] <= 1'b0;
            state_q                  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line and tag storage: loaded on fill completion, merged on write hit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == FILL && pmem_resp) begin
        data_q[index][victim_q] <= pmem_rdata;
        tag_q[index][victim_q]  <= tag;
      end else if (is_hit && mem_write) begin
        data_q[index][hit_way] <= wr_line;
      end
    end
  end
endmodule

// File: doc/param_cache.md
# param_cache

Parametrised N-way set-associative, write-back, write-allocate cache with tree pseudo-LRU replacement, between the rv32i CPU memory port and physical memory (256-bit lines). It supersedes the fixed 2-way cache. It adds configurable way and set counts, first-invalid victim selection, synchronous reset of all state, and hit/miss performance counters.

## Interface
Parameters:
- WAYS, 4: associativity; power of 2, 2..8
- SETS, 8: sets; power of 2, 2..256

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- mem_address  in  32  CPU byte address
- mem_wdata  in  32  CPU write data
- mem_byte_enable  in  4  write byte lanes (rv32i_mem_wmask)
- mem_read / mem_write  in  1  CPU request, held until mem_resp; never both high
- mem_rdata  out  32  read data, valid when mem_resp
- mem_resp  out  1  request complete
- is_hit  out  1  lookup hit, combinational
- pmem_address  out  32  line address, bits [4:0] = 0
- pmem_wdata  out  256  writeback line
- pmem_read / pmem_write  out  1  pmem request, held until pmem_resp
- pmem_rdata  in  256  fill line
- pmem_resp  in  1  pmem transfer done
- hit_count / miss_count  out  32  wrapping performance counters

## Operation
- Address split: offset [4:0], word select [4:2], index [IDX+4:5] with IDX = log2(SETS), tag = remaining upper bits.
- Per way/set: data line 256, tag, valid, dirty. Per set: WAYS-1 PLRU bits. Valid, dirty and PLRU bits are flip-flops, cleared by rst. Arrays read combinationally.
- FSM states: IDLE, WRITEBACK, FILL.
- IDLE with a request, tag match and valid: hit.
  - mem_resp=1 the same cycle; mem_rdata = selected word of the hit way.
  - On a write, the enabled byte lanes are written into the word at the edge, and dirty is set.
  - PLRU is updated at the edge.
- IDLE miss: choose the victim as the lowest-index invalid way, otherwise the PLRU victim. A dirty victim goes to WRITEBACK; otherwise to FILL. miss_count increments on this edge.
- WRITEBACK: pmem_write=1, pmem_address={victim tag, index, 5'b0}, pmem_wdata = victim line. On pmem_resp, go to FILL.
- FILL: pmem_read=1, pmem_address={req tag, index, 5'b0}. On pmem_resp, load line, tag, valid=1, dirty=0, and return to IDLE. The request is then replayed as a hit.
- hit_count increments on mem_resp only when no miss was taken for the current request (replay flag cleared on mem_resp).
- Tree PLRU uses heap indexing: root 0, children 2i+1 / 2i+2.
  - Victim walk: bit 0 selects the lower-index subtree, bit 1 the upper.
  - Access to way w sets each node on its path to point away from w.
  - For WAYS=2 this reduces to a single LRU bit.

## Timing
- Reset values: state IDLE, pmem_read=0, pmem_write=0, counters 0, all valid/dirty/PLRU 0. mem_resp and is_hit are 0 because all lines are invalid.
- Hit latency: 0 cycles (mem_resp in the request cycle).
- Clean miss: pmem_read is high from cycle 1 until the pmem_resp cycle k. mem_resp comes in cycle k+1.
- Dirty miss: the WRITEBACK span precedes FILL. pmem_read rises the cycle after the writeback pmem_resp.
- pmem_address, pmem_wdata and pmem_read/pmem_write stay stable while waiting for pmem_resp.
- rst during WRITEBACK or FILL: the transaction is aborted, pmem_read/pmem_write are 0 the next cycle, and dirty data is discarded.
- Counters wrap from 0xFFFF_FFFF to 0.

## Structure
- Package cache_types: LINE_BITS=256, OFFSET_BITS=5, and the state enum {IDLE, WRITEBACK, FILL}. rv32i_word and rv32i_mem_wmask come from rv32i_types.
- Sub-module plru_tree #(WAYS): takes the per-set bits plus accessed way, and outputs the next bits and the victim way. It is combinational and instantiated once.

## Test plan
The bench uses WAYS=4, SETS=8.
- After reset, read 0x0000_0040 with fill word0=0xDEADBEEF:
  - pmem_read is issued at 0x40, with pmem_resp after 3 cycles.
  - mem_resp and mem_rdata=0xDEADBEEF come 1 cycle later.
  - miss_count=1, hit_count=0.
- Write 0x40, byte_enable=4'b0011, wdata 0x12345678: mem_resp in the same cycle. A following read returns 0xDEAD5678 with no pmem activity, and hit_count=2.
- Victim selection and writeback:
  - Write 0x340; read 0x140, 0x240, 0x440; read 0x140 again.
  - Then read 0x540: pmem_write at 0x340 with the modified line, then pmem_read at 0x540.
- Hold pmem_resp low for 5 cycles during a fill: pmem_read and pmem_address are stable and mem_resp=0 throughout.
- Assert rst during FILL: pmem_read=0 the next cycle. Re-reading the address misses again, and miss_count restarts from 1.
- Read 0x40 twice: the second read hits with 0 latency and is_hit=1.
